// File: rtl/duc_nco_cfg_ctrl.sv
// Configuration sequencer for the DUC NCO bank: shadow/active config words, serial per-channel load, settle, datapath enable.
// Latency: apply in RUN -> START +1 -> ch0 valid +2 -> last ch valid +NUM_CH+1 -> dp_enable +NUM_CH+2+SETTLE_CYC.
// Backpressure: each channel holds valid/data until tready or TIMEOUT_CYC cycles elapse; the sequence never stalls forever.
module duc_nco_cfg_ctrl #(
    parameter int             NUM_CH      = 4,
    parameter int             DW          = 32,
    parameter int             SETTLE_CYC  = 8,
    parameter int             TIMEOUT_CYC = 64,
    parameter logic [DW-1:0]  RST_FREQ    = 32'h4000_0000
) (
    input  logic              clk_duc,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [2:0]        wr_addr,
    input  logic [DW-1:0]     wr_data,
    input  logic              apply,
    output logic [DW-1:0]     cfg_tdata,
    output logic [NUM_CH-1:0] cfg_tvalid,
    input  logic [NUM_CH-1:0] cfg_tready,
    output logic              dp_enable,
    output logic              busy,
    output logic              done,
    output logic              timeout_err,
    output logic [DW-1:0]     active_freq
);

    localparam int CHW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_MAX = (SETTLE_CYC > TIMEOUT_CYC) ? SETTLE_CYC : TIMEOUT_CYC;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0]  SETTLE_LAST  = CW'(SETTLE_CYC - 1);
    localparam logic [CW-1:0]  TIMEOUT_LAST = CW'(TIMEOUT_CYC - 1);
    localparam logic [CHW-1:0] LAST_CH      = CHW'(NUM_CH - 1);

    localparam logic [1:0] ST_START  = 2'd0;
    localparam logic [1:0] ST_ISSUE  = 2'd1;
    localparam logic [1:0] ST_SETTLE = 2'd2;
    localparam logic [1:0] ST_RUN    = 2'd3;

    // Index 0 holds the ch0 frequency word, indices 1..NUM_CH-1 the phase offsets.
    logic [DW-1:0]     shadow_q [NUM_CH];
    logic [DW-1:0]     shadow_d [NUM_CH];
    logic [DW-1:0]     active_q [NUM_CH];
    logic [DW-1:0]     active_d [NUM_CH];

    logic [1:0]        state_q, state_d;
    logic [CHW-1:0]    ch_q, ch_d;
    logic [CHW-1:0]    ch_nxt;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              pend_q, pend_d;
    logic              err_q, err_d;
    logic              done_q, done_d;
    logic [NUM_CH-1:0] tvalid_q, tvalid_d;
    logic [DW-1:0]     tdata_q, tdata_d;
    logic              hs;

    assign hs     = |(tvalid_q & cfg_tready);
    assign ch_nxt = ch_q + 1'b1;

    // Shadow writes land in any state; out-of-range addresses match no entry and are dropped.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            shadow_d[i] = shadow_q[i];
            if (wr_en && (wr_addr == 3'(i))) begin
                shadow_d[i] = wr_data;
            end
        end
    end

    // Sequencer next-state: commit, per-channel issue with timeout, settle, run.
    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        cnt_d    = cnt_q;
        pend_d   = pend_q;
        err_d    = err_q;
        done_d   = 1'b0;
        tvalid_d = tvalid_q;
        tdata_d  = tdata_q;
        for (int i = 0; i < NUM_CH; i++) begin
            active_d[i] = active_q[i];
        end

        case (state_q)
            ST_START: begin
                // Commit uses the shadow as it stood before this edge; a write in
                // this very cycle waits for the next commit.
                for (int i = 0; i < NUM_CH; i++) begin
                    active_d[i] = shadow_q[i];
                end
                err_d    = 1'b0;
                ch_d     = '0;
                cnt_d    = '0;
                tvalid_d = NUM_CH'(1);
                tdata_d  = shadow_q[0];
                state_d  = ST_ISSUE;
                if (apply) begin
                    pend_d = 1'b1;
                end
            end

            ST_ISSUE: begin
                if (apply) begin
                    pend_d = 1'b1;
                end
                if (hs || (cnt_q == TIMEOUT_LAST)) begin
                    // A handshake on the final allowed cycle still counts as success.
                    if (!hs) begin
                        err_d = 1'b1;
                    end
                    cnt_d = '0;
                    if (ch_q == LAST_CH) begin
                        tvalid_d = '0;
                        state_d  = ST_SETTLE;
                    end else begin
                        ch_d     = ch_nxt;
                        tvalid_d = tvalid_q << 1;
                        tdata_d  = active_q[ch_nxt];
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d = '0;
                    // An apply landing on the last settle cycle still forces a re-run.
                    if (pend_q || apply) begin
                        pend_d  = 1'b0;
                        state_d = ST_START;
                    end else begin
                        state_d = ST_RUN;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (apply) begin
                        pend_d = 1'b1;
                    end
                end
            end

            ST_RUN: begin
                if (apply) begin
                    state_d = ST_START;
                end
            end

            default: begin
                state_d = ST_START;
            end
        endcase
    end

    // State and register update with synchronous reset.
    always_ff @(posedge clk_duc) begin
        if (rst) begin
            state_q  <= ST_START;
            ch_q     <= '0;
            cnt_q    <= '0;
            pend_q   <= 1'b0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
            tvalid_q <= '0;
            tdata_q  <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                shadow_q[i] <= (i == 0) ? RST_FREQ : '0;
                active_q[i] <= (i == 0) ? RST_FREQ : '0;
            end
        end else begin
            state_q  <= state_d;
            ch_q     <= ch_d;
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
            err_q    <= err_d;
            done_q   <= done_d;
            tvalid_q <= tvalid_d;
            tdata_q  <= tdata_d;
            for (int i = 0; i < NUM_CH; i++) begin
                shadow_q[i] <= shadow_d[i];
                active_q[i] <= active_d[i];
            end
        end
    end

    assign cfg_tdata   = tdata_q;
    assign cfg_tvalid  = tvalid_q;
    assign dp_enable   = (state_q == ST_RUN);
    assign busy        = (state_q != ST_RUN);
    assign done        = done_q;
    assign timeout_err = err_q;
    assign active_freq = active_q[0];

endmodule

// File: tb/tb_duc_nco_cfg_ctrl.sv
// Self-checking bench for duc_nco_cfg_ctrl: step-list reference model compared every cycle plus directed scenarios.
// Latency: model and DUT are compared on the falling edge after each rising edge.
// Backpressure: cfg_tready patterns are driven per scenario, including a stuck-low channel.
module tb_duc_nco_cfg_ctrl;

    localparam int          NUM_CH      = 4;
    localparam int          DW          = 32;
    localparam int          SETTLE_CYC  = 8;
    localparam int          TIMEOUT_CYC = 64;
    localparam logic [31:0] RST_FREQ    = 32'h4000_0000;

    // Model position in the configuration sequence: 0 = commit, 1..NUM_CH = channel
    // (step-1) being offered, NUM_CH+1 = settling, NUM_CH+2 = running.
    localparam int S_START  = 0;
    localparam int S_SETTLE = NUM_CH + 1;
    localparam int S_RUN    = NUM_CH + 2;

    logic              clk;
    logic              rst;
    logic              wr_en;
    logic [2:0]        wr_addr;
    logic [DW-1:0]     wr_data;
    logic              apply;
    logic [DW-1:0]     cfg_tdata;
    logic [NUM_CH-1:0] cfg_tvalid;
    logic [NUM_CH-1:0] cfg_tready;
    logic              dp_enable;
    logic              busy;
    logic              done;
    logic              timeout_err;
    logic [DW-1:0]     active_freq;

    duc_nco_cfg_ctrl #(
        .NUM_CH      (NUM_CH),
        .DW          (DW),
        .SETTLE_CYC  (SETTLE_CYC),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .RST_FREQ    (RST_FREQ)
    ) dut (
        .clk_duc     (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .apply       (apply),
        .cfg_tdata   (cfg_tdata),
        .cfg_tvalid  (cfg_tvalid),
        .cfg_tready  (cfg_tready),
        .dp_enable   (dp_enable),
        .busy        (busy),
        .done        (done),
        .timeout_err (timeout_err),
        .active_freq (active_freq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    int          m_step  = S_START;
    int          m_cnt   = 0;
    bit          m_pend  = 0;
    bit          m_err   = 0;
    bit          m_done  = 0;
    bit          m_valid = 0;
    logic [31:0] m_tdata;
    logic [31:0] m_sh  [NUM_CH];
    logic [31:0] m_act [NUM_CH];
    logic [31:0] e_tv;

    always @(posedge clk) begin
        if (rst) begin
            m_step  = S_START;
            m_cnt   = 0;
            m_pend  = 0;
            m_err   = 0;
            m_done  = 0;
            m_tdata = 32'h0;
            for (int i = 0; i < NUM_CH; i++) begin
                m_sh[i]  = (i == 0) ? RST_FREQ : 32'h0;
                m_act[i] = (i == 0) ? RST_FREQ : 32'h0;
            end
            m_valid = 1;
        end else if (m_valid) begin
            m_done = 0;
            if (m_step == S_RUN) begin
                if (apply) m_step = S_START;
            end else if (m_step == S_START) begin
                m_act   = m_sh;
                m_err   = 0;
                m_tdata = m_sh[0];
                m_cnt   = 0;
                m_step  = 1;
                if (apply) m_pend = 1;
            end else if (m_step <= NUM_CH) begin
                if (apply) m_pend = 1;
                if (cfg_tready[m_step-1] || (m_cnt == TIMEOUT_CYC - 1)) begin
                    if (!cfg_tready[m_step-1]) m_err = 1;
                    m_cnt = 0;
                    if (m_step < NUM_CH) m_tdata = m_act[m_step];
                    m_step++;
                end else begin
                    m_cnt++;
                end
            end else begin
                if (m_cnt == SETTLE_CYC - 1) begin
                    m_cnt = 0;
                    if (m_pend || apply) begin
                        m_pend = 0;
                        m_step = S_START;
                    end else begin
                        m_step = S_RUN;
                        m_done = 1;
                    end
                end else begin
                    m_cnt++;
                    if (apply) m_pend = 1;
                end
            end
            if (wr_en && (int'(wr_addr) < NUM_CH)) m_sh[int'(wr_addr)] = wr_data;
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (m_valid) begin
            e_tv = (m_step >= 1 && m_step <= NUM_CH) ? (32'h1 << (m_step - 1)) : 32'h0;
            chk("cmp_tvalid",  32'(cfg_tvalid),  e_tv);
            chk("cmp_tdata",   cfg_tdata,        m_tdata);
            chk("cmp_dp",      32'(dp_enable),   32'(m_step == S_RUN));
            chk("cmp_busy",    32'(busy),        32'(m_step != S_RUN));
            chk("cmp_done",    32'(done),        32'(m_done));
            chk("cmp_err",     32'(timeout_err), 32'(m_err));
            chk("cmp_afreq",   active_freq,      m_act[0]);
        end
    end

    // ---------------- observation for directed checks ----------------
    int          xch[$];
    logic [31:0] xdat[$];
    int          last_xfer_cyc = 0;
    int          dp_rise_cyc   = 0;
    int          done_cnt      = 0;
    int          tv2_cnt       = 0;
    bit          dp_prev       = 0;

    always @(negedge clk) begin
        if (m_valid) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (cfg_tvalid[i] && cfg_tready[i]) begin
                    xch.push_back(i);
                    xdat.push_back(cfg_tdata);
                    last_xfer_cyc = cyc;
                end
            end
            if (dp_enable && !dp_prev) dp_rise_cyc = cyc;
            dp_prev = dp_enable;
            if (done) done_cnt++;
            if (cfg_tvalid[2]) tv2_cnt++;
        end
    end

    task automatic clear_mon();
        xch.delete();
        xdat.delete();
        done_cnt = 0;
        tv2_cnt  = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int apply_cyc = 0;

    task automatic do_apply();
        tick();
        apply     = 1'b1;
        apply_cyc = cyc;
        tick();
        apply     = 1'b0;
    endtask

    task automatic wait_dp(input int budget, input string name);
        int n;
        n = 0;
        while (!dp_enable && n < budget) begin
            tick();
            n++;
        end
        chk(name, 32'(dp_enable), 32'h1);
        tick();
    endtask

    task automatic wait_tv(input int idx, input int budget, input string name);
        int n;
        n = 0;
        while (!cfg_tvalid[idx] && n < budget) begin
            tick();
            n++;
        end
        chk(name, 32'(cfg_tvalid[idx]), 32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        wr_en      = 1'b0;
        wr_addr    = 3'd0;
        wr_data    = 32'h0;
        apply      = 1'b0;
        cfg_tready = 4'hF;
        repeat (3) tick();
        chk("rst_busy",  32'(busy),       32'h1);
        chk("rst_tv",    32'(cfg_tvalid), 32'h0);
        chk("rst_afreq", active_freq,     RST_FREQ);
        rst = 1'b0;
        clear_mon();

        // 1: power-up sequence with tready high
        wait_dp(50, "t1_run_reached");
        chk("t1_nxfer", 32'(xch.size()), 32'd4);
        for (int i = 0; i < 4; i++) chk("t1_xch", 32'(xch[i]), 32'(i));
        chk("t1_d0", xdat[0], 32'h4000_0000);
        chk("t1_d1", xdat[1], 32'h0);
        chk("t1_d3", xdat[3], 32'h0);
        chk("t1_settle_gap", 32'(dp_rise_cyc - last_xfer_cyc - 1), 32'd8);
        chk("t1_done_cnt", 32'(done_cnt), 32'd1);
        chk("t1_busy", 32'(busy), 32'h0);

        // 2: phase write then apply from RUN
        clear_mon();
        tick();
        wr_en = 1'b1; wr_addr = 3'd1; wr_data = 32'h1234_5678;
        tick();
        wr_en = 1'b0;
        do_apply();
        chk("t2_dp_fall", 32'(dp_enable), 32'h0);
        wait_dp(50, "t2_run_reached");
        chk("t2_d1", xdat[1], 32'h1234_5678);
        chk("t2_done_cnt", 32'(done_cnt), 32'd1);
        chk("t2_latency", 32'(dp_rise_cyc - apply_cyc), 32'd14);

        // 3: channel 2 never ready -> timeout
        clear_mon();
        cfg_tready = 4'b1011;
        do_apply();
        wait_dp(300, "t3_run_reached");
        chk("t3_tv2_cycles", 32'(tv2_cnt), 32'd64);
        chk("t3_err", 32'(timeout_err), 32'h1);
        chk("t3_nxfer", 32'(xch.size()), 32'd3);
        chk("t3_last_ch", 32'(xch[2]), 32'd3);
        cfg_tready = 4'hF;
        do_apply();
        tick();
        chk("t3_err_cleared", 32'(timeout_err), 32'h0);
        wait_dp(50, "t3b_run_reached");

        // 4: two applies during ISSUE collapse into one extra sequence
        clear_mon();
        do_apply();
        wait_tv(1, 20, "t4_tv1_seen");
        apply = 1'b1;
        tick();
        apply = 1'b0;
        tick();
        apply = 1'b1; wr_en = 1'b1; wr_addr = 3'd2; wr_data = 32'hCAFE_0001;
        tick();
        apply = 1'b0; wr_en = 1'b0;
        wait_dp(100, "t4_run_reached");
        chk("t4_nxfer", 32'(xch.size()), 32'd8);
        chk("t4_done_cnt", 32'(done_cnt), 32'd1);
        chk("t4_s1_d1", xdat[1], 32'h1234_5678);
        chk("t4_s1_d2", xdat[2], 32'h0);
        chk("t4_s2_d2", xdat[6], 32'hCAFE_0001);

        // 5: write and apply in the same cycle
        clear_mon();
        tick();
        wr_en = 1'b1; wr_addr = 3'd0; wr_data = 32'h0BAD_F00D; apply = 1'b1;
        tick();
        wr_en = 1'b0; apply = 1'b0;
        wait_dp(50, "t5_run_reached");
        chk("t5_d0", xdat[0], 32'h0BAD_F00D);
        chk("t5_afreq", active_freq, 32'h0BAD_F00D);

        // 6: reset in the middle of channel 1
        clear_mon();
        do_apply();
        wait_tv(1, 20, "t6_tv1_seen");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_tv",    32'(cfg_tvalid),  32'h0);
        chk("t6_tdata", cfg_tdata,        32'h0);
        chk("t6_dp",    32'(dp_enable),   32'h0);
        chk("t6_done",  32'(done),        32'h0);
        chk("t6_err",   32'(timeout_err), 32'h0);
        chk("t6_busy",  32'(busy),        32'h1);
        chk("t6_afreq", active_freq,      RST_FREQ);
        clear_mon();
        wait_dp(50, "t6_run_reached");
        chk("t6_nxfer", 32'(xch.size()), 32'd4);
        chk("t6_d0", xdat[0], 32'h4000_0000);
        chk("t6_d1", xdat[1], 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
